mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store engine fed directly by the ID/EX operation latch outputs (`memOp`, `memSize`, `rd`) plus the execute-stage address and store data. It issues single-beat requests on the data-memory valid/ready interface, aligns and extends load data, and drives `stall` back to the front-end latches while a transfer is outstanding. It is the consumer end of the latch's memory-op fields and the producer of the latch's `stall` input.

## Interface
- No parameters; all widths fixed (32-bit data/address, 5-bit register index).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `memOp` in 2: 00 none, 01 load, 10 store, 11 reserved (treated as none).
- `memSize` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `memUnsigned` in 1: load zero-extends when 1, sign-extends when 0.
- `addr` in 32: byte address (ALU result).
- `storeData` in 32: rs2 value; low bytes used per size.
- `rdIn` in 5: load destination register.
- `dmemReq` out 1: request valid.
- `dmemWe` out 1: 1 store, 0 load.
- `dmemAddr` out 32: `{addr[31:2],2'b00}`.
- `dmemByteEn` out 4: active byte lanes.
- `dmemWdata` out 32: lane-replicated store data.
- `dmemReady` in 1: request accepted when `dmemReq & dmemReady`.
- `dmemRvalid` in 1: load data valid; never in the accept cycle, earliest one cycle later.
- `dmemRdata` in 32: load word.
- `stall` out 1: holds upstream latches.
- `wbValid` out 1: one-cycle pulse, load result valid.
- `wbRd` out 5, `wbData` out 32: load writeback.
- `misalignFault` out 1: present only with `MEM_MISALIGN_TRAP_EN`.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on `memOp` 01/10, capture addr, size, unsigned, storeData, rdIn, op into internal registers; go to REQ. Otherwise stay.
- REQ: `dmemReq`=1, outputs from captured registers. Store accepted goes to DONE; load accepted goes to WAIT; not accepted stays in REQ with outputs held stable.
- WAIT: on `dmemRvalid`, capture aligned/extended data; go to DONE.
- DONE: `wbValid`=1 for loads only; unconditionally return to IDLE. The latch still presents the same op this cycle; DONE must not re-accept it.
- `stall` = (IDLE & memOp∈{01,10}) | REQ | WAIT. This is combinational from `memOp` in IDLE, so upstream holds in the same cycle the op appears.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'b1111`
- Store data replicated across lanes: byte `{4{sd[7:0]}}`, half `{2{sd[15:0]}}`, word as is.
- Load data: `dmemRdata >> (8*lane offset)`, then 8/16-bit sign or zero extend per `memUnsigned`. Word loads pass through unchanged.
- `dmemRvalid` outside WAIT is ignored.
- Reset values: state IDLE; `dmemReq`, `dmemWe`, `stall`, `wbValid`, `misalignFault` all 0; `dmemByteEn` 0; `wbRd` 0; `wbData`, `dmemAddr`, `dmemWdata` 0.
- Reset mid-transfer (REQ or WAIT): return to IDLE next edge; request dropped; no writeback.

## Timing
- Store with zero-wait `dmemReady`: stall high 2 cycles (IDLE-accept, REQ); DONE on the 3rd cycle.
- Load with ready immediate and rvalid 1 cycle later: stall high 3 cycles; `wbValid` on the 4th cycle.
- Each `dmemReady` wait cycle or `dmemRvalid` delay cycle adds exactly one stall cycle.
- Back-to-back ops: earliest next accept is the cycle after DONE.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0) issues no request.
  - IDLE goes directly to DONE with `misalignFault`=1 for that one cycle and `wbValid`=0.
  - Stall is high 1 cycle.
- Undefined:
  - No port or logic for faults.
  - Half ignores addr[0]; word ignores addr[1:0]; access proceeds normally.

## Structure
- Shared package `rv_mem_pkg`: memOp encodings, memSize encodings, FSM state enum.
- Sub-module `mem_align`: combinational byte-enable/store-replication and load shift/extend, instantiated once.

## Test plan
- Store byte, addr=0x1003, storeData=0xAABBCCDD, ready immediate → dmemAddr=0x1000, byteEn=1000, wdata=0xDDDDDDDD, stall 2 cycles, no wbValid.
- Load half signed, addr=0x2002, rdata=0x80010000, rdIn=5 → wbData=0xFFFF8001, wbRd=5, wbValid 1 cycle; unsigned variant → 0x00008001.
- Load word with dmemReady low 3 cycles, then rvalid 2 cycles later → stall extends 3+1 cycles; dmemAddr/dmemReq stable throughout REQ.
- Reset asserted during WAIT, then rvalid arrives → no wbValid, state IDLE, stall 0.
- memOp=11 or 00 held → no request, stall 0; stray rvalid ignored.
- With `MEM_MISALIGN_TRAP_EN`: load word at addr=0x3002 → no dmemReq, misalignFault 1 cycle, stall 1 cycle.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared encodings for the memory stage: memOp / memSize values and FSM states.
package rv_mem_pkg;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } mau_state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables and store replication on the way out,
// load shift plus sign/zero extension on the way back.
module mem_align
  import rv_mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_sdata,
  input  logic [31:0] i_rdata,
  input  logic        i_unsigned,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [31:0] w_shifted;

  always_comb begin
    o_byte_en = 4'b1111;
    o_wdata   = i_sdata;
    o_ldata   = i_rdata;
    w_shifted = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_byte_en = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_sdata[7:0]}};
        w_shifted = i_rdata >> {i_addr_lo, 3'b000};
        o_ldata   = i_unsigned ? {24'b0, w_shifted[7:0]}
                               : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      SZ_HALF: begin
        // addr[0] is not part of the lane select for halfwords
        o_byte_en = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata   = {2{i_sdata[15:0]}};
        w_shifted = i_rdata >> {i_addr_lo[1], 4'b0000};
        o_ldata   = i_unsigned ? {16'b0, w_shifted[15:0]}
                               : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      default: begin
        o_byte_en = 4'b1111;
        o_wdata   = i_sdata;
        o_ldata   = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: single-beat dmem requests, load alignment, upstream stall.
// Optional MEM_MISALIGN_TRAP_EN adds misalignFault and suppresses misaligned requests.
module mem_access_unit
  import rv_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  memOp,
  input  logic [1:0]  memSize,
  input  logic        memUnsigned,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  input  logic [4:0]  rdIn,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  output logic [3:0]  dmemByteEn,
  output logic [31:0] dmemWdata,
  input  logic        dmemReady,
  input  logic        dmemRvalid,
  input  logic [31:0] dmemRdata,
  output logic        stall,
  output logic        wbValid,
  output logic [4:0]  wbRd,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalignFault,
`endif
  output logic [31:0] wbData
);

  mau_state_e  r_state;
  logic [1:0]  r_size;
  logic [1:0]  r_addr_lo;
  logic        r_unsigned;
  logic [4:0]  r_rd;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_byte_en;
  logic [31:0] r_wdata;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  logic        w_accept;
  logic [1:0]  w_size;
  logic [1:0]  w_addr_lo;
  logic [3:0]  w_byte_en;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  assign w_accept = (r_state == ST_IDLE) && (memOp == OP_LOAD || memOp == OP_STORE);

  // One aligner serves both directions: live inputs while accepting, captured fields afterwards.
  assign w_size    = (r_state == ST_IDLE) ? memSize   : r_size;
  assign w_addr_lo = (r_state == ST_IDLE) ? addr[1:0] : r_addr_lo;

  mem_align u_align (
    .i_size     (w_size),
    .i_addr_lo  (w_addr_lo),
    .i_sdata    (storeData),
    .i_rdata    (dmemRdata),
    .i_unsigned (r_unsigned),
    .o_byte_en  (w_byte_en),
    .o_wdata    (w_wdata),
    .o_ldata    (w_ldata)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_fault;
  logic w_misalign;
  assign w_misalign = ((memSize == SZ_HALF) && addr[0]) || (memSize[1] && (addr[1:0] != 2'b00));
  assign misalignFault = r_fault;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_size     <= 2'b00;
      r_addr_lo  <= 2'b00;
      r_unsigned <= 1'b0;
      r_rd       <= 5'd0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_byte_en  <= 4'd0;
      r_wdata    <= 32'd0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
      r_fault    <= 1'b0;
`endif
    end else begin
      r_wb_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      r_fault    <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_size     <= memSize;
            r_addr_lo  <= addr[1:0];
            r_unsigned <= memUnsigned;
            r_rd       <= rdIn;
`ifdef MEM_MISALIGN_TRAP_EN
            if (w_misalign) begin
              r_fault <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_req     <= 1'b1;
              r_we      <= (memOp == OP_STORE);
              r_addr    <= {addr[31:2], 2'b00};
              r_byte_en <= w_byte_en;
              r_wdata   <= w_wdata;
              r_state   <= ST_REQ;
            end
`else
            r_req     <= 1'b1;
            r_we      <= (memOp == OP_STORE);
            r_addr    <= {addr[31:2], 2'b00};
            r_byte_en <= w_byte_en;
            r_wdata   <= w_wdata;
            r_state   <= ST_REQ;
`endif
          end
        end
        ST_REQ: begin
          if (dmemReady) begin
            r_req   <= 1'b0;
            r_state <= r_we ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dmemRvalid) begin
            r_wb_data  <= w_ldata;
            r_wb_rd    <= r_rd;
            r_wb_valid <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        // The latch still shows the finished op here; it is deliberately not re-accepted.
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stall      = ~reset & (w_accept | (r_state == ST_REQ) | (r_state == ST_WAIT));
  assign dmemReq    = r_req;
  assign dmemWe     = r_we;
  assign dmemAddr   = r_addr;
  assign dmemByteEn = r_byte_en;
  assign dmemWdata  = r_wdata;
  assign wbValid    = r_wb_valid;
  assign wbRd       = r_wb_rd;
  assign wbData     = r_wb_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (default build and MEM_MISALIGN_TRAP_EN build).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  memOp;
  logic [1:0]  memSize;
  logic        memUnsigned;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic [4:0]  rdIn;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [3:0]  dmemByteEn;
  logic [31:0] dmemWdata;
  logic        dmemReady;
  logic        dmemRvalid;
  logic [31:0] dmemRdata;
  logic        stall;
  logic        wbValid;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalignFault;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk         (clk),
    .reset       (reset),
    .memOp       (memOp),
    .memSize     (memSize),
    .memUnsigned (memUnsigned),
    .addr        (addr),
    .storeData   (storeData),
    .rdIn        (rdIn),
    .dmemReq     (dmemReq),
    .dmemWe      (dmemWe),
    .dmemAddr    (dmemAddr),
    .dmemByteEn  (dmemByteEn),
    .dmemWdata   (dmemWdata),
    .dmemReady   (dmemReady),
    .dmemRvalid  (dmemRvalid),
    .dmemRdata   (dmemRdata),
    .stall       (stall),
    .wbValid     (wbValid),
    .wbRd        (wbRd),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalignFault (misalignFault),
`endif
    .wbData      (wbData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] sd,
                           input int rdy_wait, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd);
    tick();
    memOp = 2'b10; memSize = sz; addr = a; storeData = sd; dmemReady = 1'b0;
    @(negedge clk);
    chk("st_accept_stall", stall, 1);
    chk("st_accept_req", dmemReq, 0);
    for (int i = 0; i <= rdy_wait; i++) begin
      tick();
      dmemReady = (i == rdy_wait);
      @(negedge clk);
      chk("st_req", dmemReq, 1);
      chk("st_we", dmemWe, 1);
      chk("st_addr", dmemAddr, exp_addr);
      chk("st_be", dmemByteEn, exp_be);
      chk("st_wdata", dmemWdata, exp_wd);
      chk("st_req_stall", stall, 1);
    end
    tick();
    dmemReady = 1'b0;
    @(negedge clk);
    chk("st_done_stall", stall, 0);
    chk("st_done_req", dmemReq, 0);
    chk("st_done_wbvalid", wbValid, 0);
    tick();
    memOp = 2'b00;
    @(negedge clk);
    chk("st_idle_req", dmemReq, 0);
    chk("st_idle_stall", stall, 0);
    $display("store addr=0x%08h size=%0d data=0x%08h ready_wait=%0d checked", a, sz, sd, rdy_wait);
  endtask

  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input int rdy_wait, input int rv_wait,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_data);
    tick();
    memOp = 2'b01; memSize = sz; memUnsigned = uns; addr = a; rdIn = rd;
    dmemReady = 1'b0; dmemRvalid = 1'b0;
    @(negedge clk);
    chk("ld_accept_stall", stall, 1);
    for (int i = 0; i <= rdy_wait; i++) begin
      tick();
      dmemReady = (i == rdy_wait);
      @(negedge clk);
      chk("ld_req", dmemReq, 1);
      chk("ld_we", dmemWe, 0);
      chk("ld_addr", dmemAddr, exp_addr);
      chk("ld_be", dmemByteEn, exp_be);
      chk("ld_req_stall", stall, 1);
    end
    for (int j = 0; j <= rv_wait; j++) begin
      tick();
      dmemReady  = 1'b0;
      dmemRvalid = (j == rv_wait);
      dmemRdata  = (j == rv_wait) ? rdata : 32'h5A5A_5A5A;
      @(negedge clk);
      chk("ld_wait_req", dmemReq, 0);
      chk("ld_wait_stall", stall, 1);
      chk("ld_wait_wbvalid", wbValid, 0);
    end
    tick();
    dmemRvalid = 1'b0;
    @(negedge clk);
    chk("ld_done_wbvalid", wbValid, 1);
    chk("ld_done_wbrd", wbRd, rd);
    chk("ld_done_wbdata", wbData, exp_data);
    chk("ld_done_stall", stall, 0);
    tick();
    memOp = 2'b00;
    @(negedge clk);
    chk("ld_idle_wbvalid", wbValid, 0);
    chk("ld_idle_stall", stall, 0);
    chk("ld_idle_req", dmemReq, 0);
    $display("load addr=0x%08h size=%0d uns=%0d rdata=0x%08h -> wbData=0x%08h (exp 0x%08h)",
             a, sz, uns, rdata, wbData, exp_data);
  endtask

  initial begin
    reset = 1'b1; memOp = 2'b00; memSize = 2'b00; memUnsigned = 1'b0; addr = 32'd0;
    storeData = 32'd0; rdIn = 5'd0; dmemReady = 1'b0; dmemRvalid = 1'b0; dmemRdata = 32'd0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_req", dmemReq, 0);
    chk("rst_we", dmemWe, 0);
    chk("rst_addr", dmemAddr, 0);
    chk("rst_be", dmemByteEn, 0);
    chk("rst_wdata", dmemWdata, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wbvalid", wbValid, 0);
    chk("rst_wbrd", wbRd, 0);
    chk("rst_wbdata", wbData, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("rst_fault", misalignFault, 0);
`endif
    $display("reset state checked");
    tick();
    reset = 1'b0;

    run_store(32'h0000_1003, 2'b00, 32'hAABB_CCDD, 0, 32'h0000_1000, 4'b1000, 32'hDDDD_DDDD);
    run_store(32'h0000_1006, 2'b01, 32'h1234_5678, 0, 32'h0000_1004, 4'b1100, 32'h5678_5678);
    run_store(32'h0000_1008, 2'b10, 32'h1234_5678, 1, 32'h0000_1008, 4'b1111, 32'h1234_5678);

    run_load(32'h0000_2002, 2'b01, 1'b0, 5'd5, 32'h8001_0000, 0, 0, 32'h0000_2000, 4'b1100, 32'hFFFF_8001);
    run_load(32'h0000_2002, 2'b01, 1'b1, 5'd5, 32'h8001_0000, 0, 0, 32'h0000_2000, 4'b1100, 32'h0000_8001);
    run_load(32'h0000_2004, 2'b10, 1'b0, 5'd9, 32'hCAFE_F00D, 3, 1, 32'h0000_2004, 4'b1111, 32'hCAFE_F00D);
    run_load(32'h0000_2011, 2'b00, 1'b0, 5'd3, 32'h1234_8056, 0, 0, 32'h0000_2010, 4'b0010, 32'hFFFF_FF80);
    run_load(32'h0000_2013, 2'b00, 1'b1, 5'd31, 32'hF100_0000, 1, 0, 32'h0000_2010, 4'b1000, 32'h0000_00F1);
    run_load(32'h0000_2000, 2'b01, 1'b0, 5'd7, 32'hFFFF_7FFE, 0, 0, 32'h0000_2000, 4'b0011, 32'h0000_7FFE);

    // Reset while waiting for read data; the late rvalid must not produce a writeback
    tick();
    memOp = 2'b01; memSize = 2'b10; memUnsigned = 1'b0; addr = 32'h0000_4000; rdIn = 5'd12;
    tick();
    dmemReady = 1'b1;
    tick();
    dmemReady = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rstw_req", dmemReq, 0);
    tick();
    reset = 1'b0; memOp = 2'b00; dmemRvalid = 1'b1; dmemRdata = 32'h1111_2222;
    @(negedge clk);
    chk("rstw_stall", stall, 0);
    chk("rstw_req_after", dmemReq, 0);
    chk("rstw_wbvalid", wbValid, 0);
    tick();
    dmemRvalid = 1'b0;
    @(negedge clk);
    chk("rstw_wbvalid2", wbValid, 0);
    chk("rstw_stall2", stall, 0);
    $display("reset during WAIT checked");

    // Reserved and idle ops do nothing; stray rvalid is ignored
    tick();
    memOp = 2'b11; addr = 32'h0000_5000;
    @(negedge clk);
    chk("rsvd_stall", stall, 0);
    tick();
    @(negedge clk);
    chk("rsvd_req", dmemReq, 0);
    chk("rsvd_stall2", stall, 0);
    tick();
    memOp = 2'b00; dmemRvalid = 1'b1; dmemRdata = 32'h3333_4444;
    @(negedge clk);
    chk("none_stall", stall, 0);
    tick();
    dmemRvalid = 1'b0;
    @(negedge clk);
    chk("stray_wbvalid", wbValid, 0);
    chk("stray_req", dmemReq, 0);
    $display("reserved/none ops and stray rvalid checked");

`ifdef MEM_MISALIGN_TRAP_EN
    tick();
    memOp = 2'b01; memSize = 2'b10; addr = 32'h0000_3002; rdIn = 5'd4;
    @(negedge clk);
    chk("mis_accept_stall", stall, 1);
    chk("mis_accept_req", dmemReq, 0);
    tick();
    @(negedge clk);
    chk("mis_fault", misalignFault, 1);
    chk("mis_req", dmemReq, 0);
    chk("mis_stall", stall, 0);
    chk("mis_wbvalid", wbValid, 0);
    tick();
    memOp = 2'b00;
    @(negedge clk);
    chk("mis_fault_clear", misalignFault, 0);
    chk("mis_req2", dmemReq, 0);
    $display("misaligned word load trapped");
`else
    run_load(32'h0000_3002, 2'b10, 1'b0, 5'd4, 32'hDEAD_BEEF, 0, 0, 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF);
    run_load(32'h0000_3003, 2'b01, 1'b1, 5'd6, 32'hABCD_0123, 0, 0, 32'h0000_3000, 4'b1100, 32'h0000_ABCD);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
